// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and shifts them out
// MSB-first on x, one bit per clock, with zero-gap back-to-back reload.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit after each word's LSB.
module bit_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift
`ifdef SER_PARITY_EN
      ,
      StPar
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             word_done_q, word_done_d;
   logic             xfer;
`ifdef SER_PARITY_EN
   logic             par_q, par_d;
`endif

   // Ready only while idle or during the final bit period of the current word.
`ifdef SER_PARITY_EN
   assign din_ready = (state_q == StIdle) || (state_q == StPar);
`else
   assign din_ready = (state_q == StIdle) || ((state_q == StShift) && (cnt_q == '0));
`endif

   assign xfer = din_valid && din_ready;

   // Next-state and next-output logic; a transfer overrides whatever the state decided.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      x_d         = IDLE_LEVEL;
      x_valid_d   = 1'b0;
      busy_d      = 1'b0;
      word_done_d = 1'b0;
`ifdef SER_PARITY_EN
      par_d       = par_q;
`endif

      unique case (state_q)
         StIdle: begin
            state_d = StIdle;
         end
         StShift: begin
            if (cnt_q != '0) begin
               shift_d   = shift_q << 1;
               cnt_d     = cnt_q - 1'b1;
               x_d       = shift_q[WIDTH-2];
               x_valid_d = 1'b1;
               busy_d    = 1'b1;
`ifndef SER_PARITY_EN
               // Next cycle shows the LSB, which is the word's last bit.
               word_done_d = (cnt_q == CNT_W'(1));
`endif
            end else begin
`ifdef SER_PARITY_EN
               state_d     = StPar;
               x_d         = par_q;
               x_valid_d   = 1'b1;
               busy_d      = 1'b1;
               word_done_d = 1'b1;
`else
               state_d = StIdle;
`endif
            end
         end
`ifdef SER_PARITY_EN
         StPar: begin
            state_d = StIdle;
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase

      // Load a new word; x shows its MSB from the next cycle on.
      if (xfer) begin
         state_d     = StShift;
         shift_d     = din;
         cnt_d       = CNT_LAST;
         x_d         = din[WIDTH-1];
         x_valid_d   = 1'b1;
         busy_d      = 1'b1;
         word_done_d = 1'b0;
`ifdef SER_PARITY_EN
         par_d       = ^din;
`endif
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         cnt_q       <= '0;
         x_q         <= IDLE_LEVEL;
         x_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         busy_q      <= busy_d;
         word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign x         = x_q;
   assign x_valid   = x_valid_q;
   assign busy      = busy_q;
   assign word_done = word_done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: each accepted word is expanded into its expected
// bit sequence; a negedge monitor pops one expected bit per valid output cycle.
module tb_bit_serializer;

   localparam int unsigned WIDTH      = 8;
   localparam logic        IDLE_LEVEL = 1'b0;
`ifdef SER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x;
   logic             x_valid;
   logic             busy;
   logic             word_done;

   bit_serializer #(
      .WIDTH      (WIDTH),
      .IDLE_LEVEL (IDLE_LEVEL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .x         (x),
      .x_valid   (x_valid),
      .busy      (busy),
      .word_done (word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Each entry: {expected bit, expected word_done}.
   logic [1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: a word is its bits MSB-first, optionally followed by its even parity.
   function automatic void model_push(input logic [WIDTH-1:0] w);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         exp_q.push_back({w[WIDTH-1-i], (i == WIDTH - 1) && !PAR});
      end
      if (PAR) exp_q.push_back({^w, 1'b1});
   endfunction

   // Monitor: compare this cycle's outputs, then record a transfer at the coming edge.
   always @(negedge clk) begin
      logic       exp_valid;
      logic [1:0] e;
      if (rst_n) begin
         exp_valid = (exp_q.size() != 0);
         chk("x_valid", x_valid, exp_valid);
         chk("busy", busy, exp_valid);
         if (exp_valid) begin
            e = exp_q.pop_front();
            chk("x", x, e[1]);
            chk("word_done", word_done, e[0]);
         end else begin
            chk("idle_x", x, IDLE_LEVEL);
            chk("idle_word_done", word_done, 1'b0);
         end
         chk("din_ready", din_ready, exp_q.size() == 0);
         if (din_valid && din_ready) model_push(din);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a word and hold it until accepted; leaves din_valid high on return.
   task automatic send(input logic [WIDTH-1:0] w);
      logic got;
      got       = 1'b0;
      din       = w;
      din_valid = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (din_ready) got = 1'b1;
      end
      chk("ready_timeout", got, 1'b1);
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         din_valid = 1'b0;
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_x", x, IDLE_LEVEL);
      chk("rst_x_valid", x_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_word_done", word_done, 1'b0);
      chk("rst_din_ready", din_ready, 1'b1);
   endtask

   initial begin
      logic drained;
      rst_n     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(2);

      // Single word, then idle.
      send(8'hB4);
      din_valid = 1'b0;
      cyc(12);

      // Back-to-back words with valid held high.
      send(8'hF0);
      send(8'h0F);
      din_valid = 1'b0;
      cyc(20);

      // Next word offered mid-word must stall until the last bit period.
      send(8'h3C);
      din_valid = 1'b0;
      din       = WIDTH'($urandom);
      cyc(2);
      send(8'hC3);
      din_valid = 1'b0;
      cyc(12);

      // Long runs spanning a word boundary.
      send(8'hFF);
      send(8'h00);
      din_valid = 1'b0;
      cyc(20);

`ifdef SER_PARITY_EN
      send(8'h07);
      din_valid = 1'b0;
      cyc(12);
      send(8'h03);
      din_valid = 1'b0;
      cyc(12);
`endif

      // Asynchronous reset after three bits of a word: abandoned immediately.
      send(8'hA5);
      din_valid = 1'b0;
      cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      cyc(1);
      rst_n = 1'b1;
      cyc(3);

      // Random words with random idle gaps.
      for (int n = 0; n < 60; n++) begin
         send(WIDTH'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            din_valid = 1'b0;
            din       = WIDTH'($urandom);
            cyc(int'($urandom_range(1, 3)));
         end
      end
      din_valid = 1'b0;

      drained = 1'b0;
      for (int k = 0; k < 100 && !drained; k++) begin
         cyc(1);
         if (exp_q.size() == 0) drained = 1'b1;
      end
      cyc(3);
      chk("drain", drained, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
